rr_online_mult_seq: RTL and testbench

Sequential, digit-serial radix-R online (MSDF) multiplier. It accepts one signed-digit pair (x_i, y_i) per accepted transfer and emits product digits most-significant first with an online delay of 3. It executes the same recurrence as the combinational unrolled multiplier stages, one iteration per cycle against a single residual register, and adds valid/ready flow control and a run-time operand length. It sits between MSDF producers and consumers (adders, further multipliers) in the rRp datapath.

---
 rtl/rr_online_mult_seq.sv | 166 ++++++++++++++++
 tb/tb_rr_online_mult_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_online_mult_seq.sv
// Digit-serial radix-R online (MSDF) multiplier, online delay 3, one recurrence step per fire.
// Single residual register plus X/Y prefix registers; valid/ready on both sides.
module rr_online_mult_seq #(
    parameter  int RADIX = 4,
    parameter  int WIDTH = 8,
    localparam int L     = $clog2(RADIX),
    localparam int D     = L + 1,
    localparam int NW    = $clog2(WIDTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [NW-1:0] n_digits_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [D-1:0]  x_digit_i,
    input  logic [D-1:0]  y_digit_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [D-1:0]  out_digit_o,
    output logic          out_last_o
);
    localparam int FB = WIDTH * L;              // prefix fraction bits
    localparam int PW = FB + 1;
    localparam int F  = FB + 3 * L;             // residual fraction bits (R^-3 folded in)
    localparam int WW = D * (WIDTH + 6) + 2;
    localparam int CW = $clog2(WIDTH + 3) + 1;

    localparam logic signed [WW-1:0] HALF = WW'(2 ** (2 * L - 1));
    localparam logic signed [WW-1:0] PMAX = WW'(RADIX - 1);
    localparam logic signed [WW-1:0] PMIN = -PMAX;

    typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_FLUSH} state_e;

    function automatic logic signed [WW-1:0] sx_p(input logic signed [PW-1:0] a);
        return {{(WW-PW){a[PW-1]}}, a};
    endfunction

    function automatic logic signed [WW-1:0] sx_d(input logic signed [D-1:0] a);
        return {{(WW-D){a[D-1]}}, a};
    endfunction

    function automatic logic signed [PW-1:0] sx_dp(input logic signed [D-1:0] a);
        return {{(PW-D){a[D-1]}}, a};
    endfunction

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d, n_q, n_d, n_in;
    logic signed [PW-1:0] x_q, x_d, y_q, y_d;
    logic signed [WW-1:0] w_q, w_d;
    logic                 out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [D-1:0]         out_digit_q, out_digit_d;

    logic                 in_ready, fire, consume, emit;
    logic signed [D-1:0]  xd, yd, p;
    logic signed [PW-1:0] x_base, y_base, x_new, y_new;
    logic signed [WW-1:0] w_base, term, v, vh, pr, w_new;
    int                   sh;

    // One recurrence step: v = R*w + (X_old*y + Y_new*x)*R^-3, select p, w' = v - p.
    always_comb begin
        consume = (state_q != S_FLUSH);
        xd      = consume ? x_digit_i : '0;
        yd      = consume ? y_digit_i : '0;
        sh      = FB - L * (int'(cnt_q) + 1);
        if (sh < 0) sh = 0;
        x_base  = (state_q == S_IDLE) ? '0 : x_q;
        y_base  = (state_q == S_IDLE) ? '0 : y_q;
        w_base  = (state_q == S_IDLE) ? '0 : w_q;
        x_new   = x_base + (sx_dp(xd) <<< sh);
        y_new   = y_base + (sx_dp(yd) <<< sh);
        term    = sx_p(x_base) * sx_d(yd) + sx_p(y_new) * sx_d(xd);
        v       = (w_base <<< L) + term;
        vh      = v >>> (F - 2 * L);
        pr      = (vh + HALF) >>> (2 * L);
        if (pr > PMAX)      pr = PMAX;
        else if (pr < PMIN) pr = PMIN;
        emit    = (state_q == S_RUN) || (state_q == S_FLUSH);
        p       = emit ? pr[D-1:0] : '0;
        w_new   = v - (sx_d(p) <<< F);
    end

    always_comb begin
        n_in = CW'(n_digits_i);
        if (n_in < CW'(4) || n_in > CW'(WIDTH)) n_in = CW'(WIDTH);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        x_d         = x_q;
        y_d         = y_q;
        w_d         = w_q;
        out_valid_d = out_valid_q;
        out_digit_d = out_digit_q;
        out_last_d  = out_last_q;
        in_ready    = 1'b0;
        fire        = 1'b0;
        unique case (state_q)
            S_IDLE, S_INIT: begin
                in_ready = 1'b1;
                fire     = in_valid_i;
            end
            S_RUN: begin
                in_ready = !out_valid_q || out_ready_i;
                fire     = in_valid_i && in_ready;
            end
            default: fire = !out_valid_q || out_ready_i;
        endcase

        if (out_ready_i) out_valid_d = 1'b0;

        if (fire) begin
            x_d   = x_new;
            y_d   = y_new;
            w_d   = w_new;
            cnt_d = cnt_q + CW'(1);
            unique case (state_q)
                S_IDLE: begin
                    n_d     = n_in;
                    state_d = S_INIT;
                end
                S_INIT:  if (cnt_q == CW'(2)) state_d = S_RUN;
                S_RUN:   if (cnt_q == n_q - CW'(1)) state_d = S_FLUSH;
                default: if (cnt_q == n_q + CW'(2)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
            if (emit) begin
                out_valid_d = 1'b1;
                out_digit_d = p;
                out_last_d  = (state_q == S_FLUSH) && (cnt_q == n_q + CW'(2));
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            n_q         <= CW'(WIDTH);
            x_q         <= '0;
            y_q         <= '0;
            w_q         <= '0;
            out_valid_q <= 1'b0;
            out_digit_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            x_q         <= x_d;
            y_q         <= y_d;
            w_q         <= w_d;
            out_valid_q <= out_valid_d;
            out_digit_q <= out_digit_d;
            out_last_q  <= out_last_d;
        end
    end

    assign in_ready_o  = rst_n_i && in_ready;
    assign out_valid_o = out_valid_q;
    assign out_digit_o = out_digit_q;
    assign out_last_o  = out_last_q;
endmodule

// File: tb/tb_rr_online_mult_seq.sv
// Bench for rr_online_mult_seq: closed-form digit model, random traffic, backpressure, reset.
module tb_rr_online_mult_seq;
    localparam int R = 4, L = 2, D = 3, W = 8, NW = 4;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic [NW-1:0] n_digits = '0;
    logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_last;
    logic [D-1:0]  x_digit = '0, y_digit = '0, out_digit;

    always #5 clk = ~clk;

    rr_online_mult_seq #(.RADIX(R), .WIDTH(W)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .n_digits_i(n_digits),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .x_digit_i(x_digit), .y_digit_i(y_digit),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_digit_o(out_digit), .out_last_o(out_last)
    );

    typedef struct {
        int     d;
        bit     last;
        int     idx;
        int     n;
        longint xy;
        bit     ns;
    } exp_t;

    int     total = 0, bad = 0, cyc = 0;
    bit     mon_en = 1'b0, rdy_rand = 1'b0;
    exp_t   exp_q[$];
    int     acc_q[$];
    int     xa[0:W], ya[0:W];

    task automatic chk(input string tag, input longint got, input longint want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Digit p_{j+1} is selected from v_j = R^{j+1} * (X_{j+4}*Y_{j+4} - P_j), truncated to R^-2.
    // Values are integers scaled by R^W (prefixes) and R^2W (products, P).
    function automatic void model(input int n, input int xs[0:W], input int ys[0:W],
                                  output int dg[0:W], output longint xy);
        longint xk, yk, pacc, diff, vh, p;
        int k;
        pacc = 0;
        for (int i = 0; i <= W; i++) dg[i] = 0;
        for (int j = 0; j < n; j++) begin
            k = (j + 4 < n) ? j + 4 : n;
            xk = 0; yk = 0;
            for (int i = 1; i <= k; i++) begin
                xk += longint'(xs[i]) * (longint'(1) << (L * (W - i)));
                yk += longint'(ys[i]) * (longint'(1) << (L * (W - i)));
            end
            diff = xk * yk - pacc;
            vh   = diff >>> (L * (2 * W - j - 3));
            p    = (vh + longint'(R * R / 2)) >>> (2 * L);
            if (p > R - 1) p = R - 1;
            if (p < -(R - 1)) p = -(R - 1);
            dg[j+1] = int'(p);
            pacc += p * (longint'(1) << (L * (2 * W - j - 1)));
        end
        xk = 0; yk = 0;
        for (int i = 1; i <= n; i++) begin
            xk += longint'(xs[i]) * (longint'(1) << (L * (W - i)));
            yk += longint'(ys[i]) * (longint'(1) << (L * (W - i)));
        end
        xy = xk * yk;
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        out_ready = rdy_rand ? ($urandom_range(0, 99) < 30) : 1'b1;
    end

    exp_t   e;
    longint pacc, err;
    int     od;
    bit     hold_v = 1'b0;
    logic [D-1:0] hold_d;

    always @(negedge clk) begin
        if (!mon_en) hold_v = 1'b0;
        else begin
            if (hold_v) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_digit", out_digit, hold_d);
            end
            hold_v = out_valid && !out_ready;
            hold_d = out_digit;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
                else begin
                    e  = exp_q.pop_front();
                    od = int'($signed(out_digit));
                    chk("digit", od, e.d);
                    chk("last", out_last, e.last);
                    chk("range", (od >= -(R - 1) && od <= R - 1), 1);
                    if (e.idx == 1) pacc = 0;
                    pacc += longint'(od) * (longint'(1) << (L * (2 * W - e.idx)));
                    if (e.idx == 1 && e.ns && acc_q.size() > 0) chk("lat_first", cyc - acc_q[0], 4);
                    if (e.last) begin
                        err = e.xy - pacc;
                        if (err < 0) err = -err;
                        chk("err_bound", err <= (longint'(1) << (L * (2 * W - e.n))), 1);
                        if (e.ns && acc_q.size() > 0) chk("lat_last", cyc - acc_q[0], e.n + 3);
                        if (acc_q.size() > 0) void'(acc_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic send_op(input int nf, input int xs[0:W], input int ys[0:W],
                           input bit ns, input bit b2b);
        int n, t;
        int dg[0:W];
        longint xy;
        exp_t en;
        n = (nf < 4 || nf > W) ? W : nf;
        model(n, xs, ys, dg, xy);
        for (int i = 1; i <= n; i++) begin
            en.d = dg[i]; en.last = (i == n); en.idx = i; en.n = n; en.xy = xy; en.ns = ns;
            exp_q.push_back(en);
        end
        for (int i = 1; i <= n; i++) begin
            if (!ns) begin
                t = 0;
                while ($urandom_range(0, 99) < 30 && t < 8) begin
                    in_valid = 1'b0;
                    x_digit  = D'($urandom);
                    @(posedge clk); #1;
                    t++;
                end
            end
            in_valid = 1'b1;
            x_digit  = xs[i][D-1:0];
            y_digit  = ys[i][D-1:0];
            n_digits = (i == 1) ? NW'(nf) : NW'($urandom_range(0, 15));
            t = 0;
            @(negedge clk);
            while (!in_ready && t < 2000) begin @(negedge clk); t++; end
            if (t >= 2000) chk("in_timeout", t, 0);
            if (i == 1) begin
                acc_q.push_back(cyc);
                if (b2b) chk("b2b_last_pending", out_valid && out_last, 1);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        x_digit  = D'($urandom);
        y_digit  = D'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 5000) begin @(negedge clk); t++; end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
            acc_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic fill(input int xv, input int yv);
        for (int i = 0; i <= W; i++) begin xa[i] = (i == 0) ? 0 : xv; ya[i] = (i == 0) ? 0 : yv; end
    endtask

    task automatic rand_op(input bit ns);
        int nf, kind;
        kind = $urandom_range(0, 9);
        nf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(4, W));
        for (int i = 1; i <= W; i++) begin
            case (kind)
                0:       begin xa[i] = R - 1; ya[i] = R - 1; end
                1:       begin xa[i] = R - 1; ya[i] = -(R - 1); end
                default: begin
                    xa[i] = int'($urandom_range(0, 2 * R - 2)) - (R - 1);
                    ya[i] = int'($urandom_range(0, 2 * R - 2)) - (R - 1);
                end
            endcase
        end
        send_op(nf, xa, ya, ns, 1'b0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_digit", out_digit, 0);
            chk("rst_out_last", out_last, 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        @(posedge clk); #1;
        mon_en = 1'b1;

        fill(0, 0);                     send_op(8, xa, ya, 1'b1, 1'b0);
        fill(0, 0); xa[1] = 3; ya[1] = 2; send_op(8, xa, ya, 1'b1, 1'b0);
        fill(3, 3);                     send_op(8, xa, ya, 1'b1, 1'b0);
        fill(3, -3);                    send_op(8, xa, ya, 1'b1, 1'b0);
        drain();

        fill(3, 3);   send_op(4, xa, ya, 1'b1, 1'b0);
        fill(-2, 1);  send_op(4, xa, ya, 1'b1, 1'b1);
        fill(1, -3);  send_op(2, xa, ya, 1'b1, 1'b0);
        drain();

        repeat (300) rand_op(1'b1);
        drain();

        rdy_rand = 1'b1;
        repeat (600) rand_op(1'b0);
        drain();
        rdy_rand = 1'b0;
        @(posedge clk); #1;

        // abort an operation partway through RUN
        mon_en = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1;
            x_digit  = D'(3);
            y_digit  = D'(-2);
            n_digits = NW'(8);
            @(negedge clk);
            for (int t = 0; t < 50 && !in_ready; t++) @(negedge clk);
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_digit", out_digit, 0);
        chk("midrst_out_last", out_last, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_idle_ready", in_ready, 1);
        @(posedge clk); #1;
        mon_en = 1'b1;
        fill(2, -1); xa[3] = -3; ya[5] = 3;
        send_op(8, xa, ya, 1'b1, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
